// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller: reads a 16-bit word at pc from a synchronous
// instruction memory, hands it to the cpu with a load/start pair, and waits for completion.
module fetch_sequencer #(
  parameter int AW       = 8,
  parameter int START_PC = 0,
  parameter int TIMEOUT  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          step,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  input  logic [15:0]   mem_rdata,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic          cpu_w,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          illegal,
  output logic [15:0]   retired,
  output logic [2:0]    dbg_state
);

  // Handshake: cpu_load and cpu_s are single-cycle pulses; the cpu acknowledges a start by
  // dropping cpu_w at least once and signals completion by raising it again.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_LOAD   = 3'd3,
    S_START  = 3'd4,
    S_BUSY   = 3'd5,
    S_RETIRE = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  localparam logic [AW-1:0] PC_RESET = AW'(START_PC);
  localparam logic [3:0]    CNT_LAST = 4'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_hold;
  logic [15:0]   r_retired;
  logic [3:0]    r_cnt;
  logic          r_seen;
  logic          r_single;
  logic          r_illegal;
  logic          r_mem_read;
  logic          r_cpu_load;
  logic          r_cpu_s;
  logic          r_busy;
  logic          r_halted;
  logic          w_timeout;
  logic          w_is_halt;

  assign w_is_halt = (mem_rdata[15:13] == 3'b111);

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:   if (run || step) w_next = S_FETCH;
      S_FETCH:  w_next = S_LATCH;
      S_LATCH:  w_next = w_is_halt ? S_HALTED : S_LOAD;
      S_LOAD:   w_next = S_START;
      S_START:  w_next = S_BUSY;
      S_BUSY: begin
        if (r_seen && cpu_w) begin
          w_next = S_RETIRE;
        end else if (!r_seen && cpu_w && (r_cnt == CNT_LAST)) begin
          // The cpu never acknowledged the start: retire the word as illegal.
          w_timeout = 1'b1;
          w_next    = S_RETIRE;
        end
      end
      S_RETIRE: w_next = (run && !r_single) ? S_FETCH : S_IDLE;
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_RESET;
      r_hold     <= 16'd0;
      r_retired  <= 16'd0;
      r_cnt      <= 4'd0;
      r_seen     <= 1'b0;
      r_single   <= 1'b0;
      r_illegal  <= 1'b0;
      r_mem_read <= 1'b0;
      r_cpu_load <= 1'b0;
      r_cpu_s    <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_FETCH) r_single <= ~run;
      if (r_state == S_LATCH) r_hold <= mem_rdata;
      if (r_state == S_START) begin
        r_seen <= 1'b0;
        r_cnt  <= 4'd0;
      end
      if (r_state == S_BUSY) begin
        if (!cpu_w) r_seen <= 1'b1;
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_timeout) r_illegal <= 1'b1;
      if (r_state == S_RETIRE) begin
        r_pc      <= r_pc + AW'(1);
        r_retired <= r_retired + 16'd1;
      end
      // Strobes are decoded from the next state so they line up with the state they belong to.
      r_mem_read <= (w_next == S_FETCH);
      r_cpu_load <= (w_next == S_LOAD);
      r_cpu_s    <= (w_next == S_START);
      r_busy     <= (w_next != S_IDLE) && (w_next != S_HALTED);
      r_halted   <= (w_next == S_HALTED);
    end
  end

  assign mem_addr  = r_pc;
  assign pc        = r_pc;
  assign mem_read  = r_mem_read;
  assign cpu_in    = r_hold;
  assign cpu_load  = r_cpu_load;
  assign cpu_s     = r_cpu_s;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign retired   = r_retired;
  assign dbg_state = r_state;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch/issue controller that sits in front of the cpu block and a synchronous instruction memory.
- Reads 16-bit instructions at a program counter, loads each into the cpu instruction register, and pulses start.
- Waits for the cpu's w handshake, then advances the PC.
- Provides run/single-step control, a HALT opcode, a retired-instruction counter and a hung-instruction guard.

Parameters:
- AW, 8, instruction memory address width; PC width.
- START_PC, 0, PC value after reset.
- TIMEOUT, 4, cycles in BUSY without observing cpu_w=0 before the instruction is forced retired as illegal; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; 0 at a clk edge resets the block.
- run  input  1  level; while 1, fetch and execute continuously.
- step  input  1  one-cycle pulse; sampled only in IDLE; executes exactly one instruction.
- mem_addr  output  AW  instruction memory read address.
- mem_read  output  1  read strobe; data is returned on mem_rdata in the following cycle.
- mem_rdata  input  16  instruction memory read data.
- cpu_in  output  16  instruction word driven to the cpu in input.
- cpu_load  output  1  cpu instruction-register load enable.
- cpu_s  output  1  cpu start.
- cpu_w  input  1  cpu waiting/idle flag.
- pc  output  AW  address of the current or next instruction.
- busy  output  1  1 in every state except IDLE and HALTED.
- halted  output  1  HALT opcode reached.
- illegal  output  1  sticky; a timeout retirement occurred.
- retired  output  16  count of retired instructions.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at an edge) has priority over everything and may occur in any state:
  - state goes to IDLE;
  - pc=START_PC;
  - mem_read, cpu_load, cpu_s, busy, halted and illegal go to 0;
  - retired=0;
  - cpu_in and the internal hold register go to 0.
- Because all outputs are registered, cpu_load and cpu_s are 0 on the cycle after reset.
- States: IDLE, FETCH, LATCH, LOAD, START, BUSY, RETIRE, HALTED.
- IDLE:
  - If run=1 or step=1, go to FETCH and record single=~run.
  - If both are 1, run wins.
- FETCH:
  - mem_read=1, mem_addr=pc.
  - Next state is LATCH.
- LATCH:
  - Capture mem_rdata into the hold register; cpu_in follows the hold register.
  - If mem_rdata[15:13]=3'b111 (HALT), go to HALTED; pc is not incremented and retired does not count the HALT.
  - Otherwise go to LOAD.
- LOAD:
  - cpu_load=1 for exactly one cycle; cpu_in is stable.
  - Next state is START.
- START:
  - cpu_s=1 for exactly one cycle.
  - Clear the seen_busy flag and the timeout counter.
  - Next state is BUSY.
- BUSY (cpu_s=0):
  - cpu_w=0 sets seen_busy.
  - If seen_busy=1 and cpu_w=1, go to RETIRE.
  - If seen_busy=0 and the counter reaches TIMEOUT, set illegal=1 and go to RETIRE.
  - Otherwise increment the counter.
- RETIRE:
  - pc<=pc+1, wrapping from 2^AW-1 to 0.
  - retired<=retired+1, wrapping at 16 bits.
  - Next state is FETCH if run=1 and single=0; otherwise IDLE.
- HALTED:
  - halted=1, busy=0.
  - Stays in HALTED until reset; run and step are ignored.
- Deasserting run in any state from FETCH through BUSY completes the current instruction, then returns to IDLE.
- step pulses outside IDLE are ignored.
- Minimum issue period is FETCH+LATCH+LOAD+START+BUSY(k)+RETIRE = 5+k cycles.
- cpu_load and cpu_s are never asserted in the same cycle.
- mem_read is asserted only in FETCH.

Test Plan:
- Reset with mem[0]=16'hD007 (MOV R0,#7), run=1 held: FETCH at addr 0; cpu_load then cpu_s pulse one cycle each; after the cpu w handshake, pc=1 and retired=1.
- Program MOV R0,#7; MOV R1,#2; ADD R2,R1,R0; HALT(16'hE000), run=1: retired=3, halted=1, pc=3, cpu out=9, busy=0 thereafter.
- IDLE with step pulsed once, mem[0]=16'hD105: exactly one instruction is issued; returns to IDLE with pc=1, retired=1; no further mem_read until the next step.
- Unsupported opcode 16'h0000 (cpu never drops w), TIMEOUT=4: BUSY lasts 4 cycles; illegal=1; pc advances to 1; execution continues.
- AW=2, START_PC=3, run=1, mem[3]=MOV, mem[0]=HALT: pc wraps 3->0 and halted=1 at pc=0.
- Assert reset=0 during BUSY: next cycle state is IDLE, pc=START_PC, retired=0, illegal=0, cpu_s=0, cpu_load=0.
